// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision field widths, the packed
// fp32 result layout and the sequencer state encoding.
package fpu_pkg;

  localparam int unsigned FP_BIAS   = 127;
  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_MAN_W  = 23;
  localparam int unsigned I2F_WIDTH = 32;

  // IEEE single: sign, biased exponent, fraction without the hidden bit.
  typedef struct packed {
    logic                s;
    logic [FP_EXP_W-1:0] e;
    logic [FP_MAN_W-1:0] m;
  } fp32_t;

  typedef enum logic [2:0] {
    GET_A,
    SPECIAL,
    CONVERT,
    NORM,
    ROUND,
    PACK,
    PUT_Z
  } i2f_state_t;

endpackage

// File: rtl/int_to_float_if.sv
// Valid/ack bus for the integer-to-float converter.
//   input_a_stb/input_a_ack : operand handshake, carries input_a and is_unsigned
//   output_z_stb/output_z_ack : result handshake, carries output_z (IEEE single)
// master = operand producer / result consumer, slave = the converter.
interface int_to_float_if;
  import fpu_pkg::*;

  logic                 input_a_stb;
  logic                 input_a_ack;
  logic [I2F_WIDTH-1:0] input_a;
  logic                 is_unsigned;
  logic                 output_z_stb;
  logic                 output_z_ack;
  logic [I2F_WIDTH-1:0] output_z;

  modport master (
    output input_a_stb, input_a, is_unsigned, output_z_ack,
    input  input_a_ack, output_z_stb, output_z
  );

  modport slave (
    input  input_a_stb, input_a, is_unsigned, output_z_ack,
    output input_a_ack, output_z_stb, output_z
  );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised 24-bit mantissa (hidden bit included).
//   man       : mantissa before rounding, man[MSB] = 1
//   g, r, st  : guard, round and sticky bits below the mantissa LSB
//   man_rnd_c : rounded mantissa, renormalised to 1.0 on carry-out
//   exp_inc_c : rounding overflowed the mantissa; exponent must be bumped
module fp_round_rne
  import fpu_pkg::*;
(
  input  logic [FP_MAN_W:0] man,
  input  logic              g,
  input  logic              r,
  input  logic              st,
  output logic [FP_MAN_W:0] man_rnd_c,
  output logic              exp_inc_c
);

  localparam int unsigned SUM_W = FP_MAN_W + 2;

  logic             round_up;
  logic [SUM_W-1:0] sum;

  // Round up above half, or at exactly half when the LSB is odd.
  always_comb begin
    round_up  = g & (r | st | man[0]);
    sum       = {1'b0, man} + SUM_W'(round_up);
    exp_inc_c = sum[SUM_W-1];
    man_rnd_c = exp_inc_c ? {1'b1, {FP_MAN_W{1'b0}}} : sum[FP_MAN_W:0];
  end

endmodule

// File: rtl/int_to_float.sv
// 32-bit signed/unsigned integer to IEEE single converter (fcvt.s.w / .wu).
// One operation in flight; normalisation shifts one bit per cycle, RNE rounding.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   bus   : int_to_float_if.slave (operand in, result out, valid/ack each side)
module int_to_float
  import fpu_pkg::*;
#(
  parameter int unsigned WIDTH = I2F_WIDTH,
  parameter int unsigned BIAS  = FP_BIAS
) (
  input  logic          clk,
  input  logic          rst,
  int_to_float_if.slave bus
);

  localparam int unsigned EXP_IW  = 9;
  // Bit position of the rounded mantissa LSB inside the normalised magnitude.
  localparam int unsigned RND_LSB = WIDTH - FP_MAN_W - 1;

  i2f_state_t               state_q, state_n;
  logic [WIDTH-1:0]         mag_q,   mag_n;
  logic signed [EXP_IW-1:0] e_q,     e_n;
  logic                     s_q,     s_n;
  logic                     uns_q,   uns_n;
  logic                     zero_q,  zero_n;
  logic                     ack_q,   ack_n;
  logic                     stb_q,   stb_n;
  fp32_t                    z_q,     z_n;

  logic [FP_MAN_W:0]        man_rnd_c;
  logic                     exp_inc_c;

  fp_round_rne u_round (
    .man       (mag_q[WIDTH-1:RND_LSB]),
    .g         (mag_q[RND_LSB-1]),
    .r         (mag_q[RND_LSB-2]),
    .st        (|mag_q[RND_LSB-3:0]),
    .man_rnd_c (man_rnd_c),
    .exp_inc_c (exp_inc_c)
  );

  assign bus.input_a_ack  = ack_q;
  assign bus.output_z_stb = stb_q;
  assign bus.output_z     = z_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= GET_A;
      mag_q   <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      uns_q   <= 1'b0;
      zero_q  <= 1'b0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
      z_q     <= '0;
    end else begin
      state_q <= state_n;
      mag_q   <= mag_n;
      e_q     <= e_n;
      s_q     <= s_n;
      uns_q   <= uns_n;
      zero_q  <= zero_n;
      ack_q   <= ack_n;
      stb_q   <= stb_n;
      z_q     <= z_n;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_n = state_q;
    mag_n   = mag_q;
    e_n     = e_q;
    s_n     = s_q;
    uns_n   = uns_q;
    zero_n  = zero_q;
    ack_n   = ack_q;
    stb_n   = stb_q;
    z_n     = z_q;

    case (state_q)
      GET_A: begin
        ack_n = 1'b1;
        if (bus.input_a_stb && ack_q) begin
          mag_n   = bus.input_a;
          uns_n   = bus.is_unsigned;
          ack_n   = 1'b0;
          state_n = SPECIAL;
        end
      end

      SPECIAL: begin
        zero_n  = (mag_q == '0);
        state_n = (mag_q == '0) ? PACK : CONVERT;
      end

      // Negation wraps 0x80000000 onto itself, which is the correct magnitude.
      CONVERT: begin
        s_n     = ~uns_q & mag_q[WIDTH-1];
        mag_n   = s_n ? (~mag_q + WIDTH'(1)) : mag_q;
        e_n     = EXP_IW'(WIDTH - 1);
        state_n = NORM;
      end

      NORM: begin
        if (!mag_q[WIDTH-1]) begin
          mag_n = mag_q << 1;
          e_n   = e_q - EXP_IW'(1);
        end else begin
          state_n = ROUND;
        end
      end

      // Rounded mantissa goes back into the top of mag; low bits are spent.
      ROUND: begin
        mag_n   = {man_rnd_c, {RND_LSB{1'b0}}};
        e_n     = e_q + EXP_IW'(exp_inc_c);
        state_n = PACK;
      end

      PACK: begin
        if (zero_q) begin
          z_n = '0;
        end else begin
          z_n.s = s_q;
          z_n.e = FP_EXP_W'(e_q + EXP_IW'(BIAS));
          z_n.m = mag_q[WIDTH-2 -: FP_MAN_W];
        end
        stb_n   = 1'b1;
        state_n = PUT_Z;
      end

      PUT_Z: begin
        if (bus.output_z_ack) begin
          stb_n   = 1'b0;
          ack_n   = 1'b1;
          state_n = GET_A;
        end
      end

      default: begin
        state_n = GET_A;
      end
    endcase
  end

endmodule

// File: tb/tb_int_to_float.sv
// Bench for int_to_float: directed vector table, hold/reset sequences and
// random operands checked against an arithmetic reference model.
module tb_int_to_float;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_to_float_if bus ();

  int_to_float dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic        uns;
    logic [31:0] z;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Real-number view: find the exponent of the magnitude, divide down to 24
  // significant bits and round the remainder to nearest, ties to even.
  function automatic void ref_model(input logic [31:0] a, input logic uns,
                                    output logic [31:0] z, output int lat);
    longint mag, q, rem, half;
    bit     s;
    int     e;
    if (a == 32'h0) begin
      z   = 32'h0;
      lat = 2;
      return;
    end
    s   = !uns && a[31];
    mag = s ? ((longint'(1) << 32) - longint'(a)) : longint'(a);
    e   = 0;
    while ((mag >> (e + 1)) != 0) e++;
    lat = 5 + (31 - e);
    if (e > 23) begin
      q    = mag >> (e - 23);
      rem  = mag - (q << (e - 23));
      half = longint'(1) << (e - 24);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end else begin
      q = mag << (23 - e);
    end
    z = {s, 8'(e + 127), 23'(q)};
  endfunction

  // One transaction; while the result is held, output and handshake must stay put.
  task automatic do_op(input logic [31:0] a, input logic uns, input int hold,
                       input logic [31:0] exp_z, input string name,
                       output logic [31:0] z, output int lat);
    int w;
    @(negedge clk);
    bus.input_a     = a;
    bus.is_unsigned = uns;
    bus.input_a_stb = 1'b1;
    w = 0;
    while (!bus.input_a_ack && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 100) begin
      errors++;
      $display("FAIL %s accept_timeout actual=%0d required<100", name, w);
      bus.input_a_stb = 1'b0;
      z   = 'x;
      lat = -1;
      return;
    end
    @(posedge clk);
    #1 bus.input_a_stb = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus.output_z_stb && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat >= 200) begin
      errors++;
      $display("FAIL %s result_timeout actual=%0d required<200", name, lat);
      z = 'x;
      return;
    end
    z = bus.output_z;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check32($sformatf("%s hold%0d z", name, i), bus.output_z, exp_z);
      check32($sformatf("%s hold%0d stb", name, i), 32'(bus.output_z_stb), 32'h1);
      check32($sformatf("%s hold%0d in_ack", name, i), 32'(bus.input_a_ack), 32'h0);
    end
    bus.output_z_ack = 1'b1;
    @(posedge clk);
    #1 bus.output_z_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] z, ez, a;
    logic        uns;
    int          lat, elat, w, hold;

    vecs[0]  = '{32'h00000001, 1'b0, 32'h3F800000, 36};
    vecs[1]  = '{32'hFFFFFFFF, 1'b0, 32'hBF800000, 36};
    vecs[2]  = '{32'h80000000, 1'b0, 32'hCF000000, 5};
    vecs[3]  = '{32'h80000000, 1'b1, 32'h4F000000, 5};
    vecs[4]  = '{32'hFFFFFFFF, 1'b1, 32'h4F800000, 5};
    vecs[5]  = '{32'h01000001, 1'b0, 32'h4B800000, 12};
    vecs[6]  = '{32'h01000003, 1'b0, 32'h4B800002, 12};
    vecs[7]  = '{32'h01000005, 1'b0, 32'h4B800002, 12};
    vecs[8]  = '{32'h7FFFFFFF, 1'b0, 32'h4F000000, 6};
    vecs[9]  = '{32'h00FFFFFF, 1'b1, 32'h4B7FFFFF, 13};
    vecs[10] = '{32'h00000007, 1'b0, 32'h40E00000, 34};
    vecs[11] = '{32'hFFFFFFF9, 1'b0, 32'hC0E00000, 34};
    vecs[12] = '{32'h00000000, 1'b1, 32'h00000000, 2};

    rst              = 1'b0;
    bus.input_a_stb  = 1'b0;
    bus.input_a      = '0;
    bus.is_unsigned  = 1'b0;
    bus.output_z_ack = 1'b0;
    repeat (2) @(negedge clk);
    check32("reset in_ack", 32'(bus.input_a_ack), 32'h0);
    check32("reset out_stb", 32'(bus.output_z_stb), 32'h0);
    check32("reset out_z", bus.output_z, 32'h0);
    rst = 1'b1;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].a, vecs[i].uns, 0, vecs[i].z, $sformatf("vec%0d", i), z, lat);
      check32($sformatf("vec%0d z a=%08h", i, vecs[i].a), z, vecs[i].z);
      check_int($sformatf("vec%0d latency", i), lat, vecs[i].lat);
    end

    // Zero result held under backpressure.
    do_op(32'h0, 1'b0, 10, 32'h0, "zero_hold", z, lat);
    check32("zero_hold z", z, 32'h0);
    check_int("zero_hold latency", lat, 2);

    // Reset while normalising 0x10 discards the operation.
    @(negedge clk);
    bus.input_a     = 32'h00000010;
    bus.is_unsigned = 1'b0;
    bus.input_a_stb = 1'b1;
    w = 0;
    while (!bus.input_a_ack && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_int("midrst accept wait bounded", int'(w < 100), 1);
    @(posedge clk);
    #1 bus.input_a_stb = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check32("midrst out_stb", 32'(bus.output_z_stb), 32'h0);
    check32("midrst in_ack", 32'(bus.input_a_ack), 32'h0);
    check32("midrst state", 32'(dut.state_q), 32'(GET_A));
    @(negedge clk);
    rst = 1'b1;
    do_op(32'h7, 1'b0, 0, 32'h40E00000, "after_rst", z, lat);
    check32("after_rst z", z, 32'h40E00000);
    check_int("after_rst latency", lat, 34);

    // Random operands spread over all leading-zero counts, random backpressure.
    for (int i = 0; i < 1000; i++) begin
      a    = $urandom >> $urandom_range(0, 31);
      uns  = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      ref_model(a, uns, ez, elat);
      do_op(a, uns, hold, ez, $sformatf("rnd%0d", i), z, lat);
      check32($sformatf("rnd%0d z a=%08h u=%0d", i, a, uns), z, ez);
      check_int($sformatf("rnd%0d latency a=%08h u=%0d", i, a, uns), lat, elat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
